// File: rtl/mmio_register_bank.sv
// MMIO register bank: NUM_CTRL read/write control words, NUM_STATUS live status
// words, a write-1-to-clear EVENT register fed by rising edges on status word 0,
// and a MASK register gating the level interrupt. One request in flight at a time.
module mmio_register_bank #(
    parameter logic [31:0] BASE_ADDR  = 32'h20,
    parameter int unsigned NUM_CTRL   = 6,
    parameter int unsigned NUM_STATUS = 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      req_valid,
    input  logic                      req_write,
    input  logic [31:0]               req_addr,
    input  logic [31:0]               req_wdata,
    output logic                      req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_error,
    input  logic [32*NUM_STATUS-1:0]  status_in,
    output logic [32*NUM_CTRL-1:0]    ctrl_out,
    output logic [NUM_CTRL-1:0]       ctrl_wstrobe,
    output logic                      irq
);

    localparam logic [31:0] STATUS_OFF = 32'(NUM_CTRL);
    localparam logic [31:0] EVENT_OFF  = 32'(NUM_CTRL + NUM_STATUS);
    localparam logic [31:0] MASK_OFF   = EVENT_OFF + 32'd1;

    typedef enum logic [0:0] {StIdle, StResp} state_e;

    state_e state_q, state_d;

    logic [NUM_CTRL-1:0][31:0] ctrl_q;
    logic [31:0]               event_q, event_d;
    logic [31:0]               mask_q;
    logic [31:0]               status_prev_q;
    logic                      hist_valid_q;
    logic [31:0]               rsp_rdata_q, rsp_rdata_d;
    logic                      rsp_error_q, rsp_error_d;
    logic [NUM_CTRL-1:0]       wstrobe_q, wstrobe_d;

    logic                      accept;
    logic                      above_base;
    logic [31:0]               offset;
    logic [NUM_CTRL-1:0]       hit_ctrl;
    logic [NUM_STATUS-1:0]     hit_status;
    logic                      hit_event;
    logic                      hit_mask;
    logic [31:0]               read_data;
    logic                      addr_error;
    logic [31:0]               status0;
    logic [31:0]               rise;
    logic [31:0]               w1c;

    assign accept     = req_valid && req_ready;
    assign above_base = (req_addr >= BASE_ADDR);
    assign offset     = req_addr - BASE_ADDR;

    // FSM next state and handshake outputs
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) state_d = StResp;
            end
            StResp: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= StIdle;
        else          state_q <= state_d;
    end

    // Address decode and read mux; below-base addresses are excluded so the
    // wrapped offset cannot alias onto a register
    always_comb begin
        hit_ctrl   = '0;
        hit_status = '0;
        hit_event  = 1'b0;
        hit_mask   = 1'b0;
        read_data  = '0;
        if (above_base) begin
            for (int unsigned i = 0; i < NUM_CTRL; i++) begin
                if (offset == 32'(i)) begin
                    hit_ctrl[i] = 1'b1;
                    read_data   = ctrl_q[i];
                end
            end
            for (int unsigned j = 0; j < NUM_STATUS; j++) begin
                if (offset == STATUS_OFF + 32'(j)) begin
                    hit_status[j] = 1'b1;
                    read_data     = status_in[32*j +: 32];
                end
            end
            if (offset == EVENT_OFF) begin
                hit_event = 1'b1;
                read_data = event_q;
            end
            if (offset == MASK_OFF) begin
                hit_mask  = 1'b1;
                read_data = mask_q;
            end
        end
    end

    // Writes to read-only status words are reported like unmapped addresses
    assign addr_error = !((|hit_ctrl) || (|hit_status) || hit_event || hit_mask)
                        || (req_write && (|hit_status));

    // Response capture at acceptance, held otherwise; strobe lasts one cycle
    always_comb begin
        rsp_rdata_d = rsp_rdata_q;
        rsp_error_d = rsp_error_q;
        wstrobe_d   = '0;
        if (accept) begin
            rsp_error_d = addr_error;
            rsp_rdata_d = (req_write || addr_error) ? 32'd0 : read_data;
            if (req_write) wstrobe_d = hit_ctrl;
        end
    end

    // Edge history is not trusted until one clock after reset, so bits already
    // high at deassertion never count as rising
    assign status0 = status_in[31:0];
    assign rise    = hist_valid_q ? (status0 & ~status_prev_q) : 32'd0;
    assign w1c     = (accept && req_write && hit_event) ? req_wdata : 32'd0;
    assign event_d = (event_q & ~w1c) | rise;

    // Register file, event capture and response registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q        <= '0;
            event_q       <= '0;
            mask_q        <= '0;
            status_prev_q <= '0;
            hist_valid_q  <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
            wstrobe_q     <= '0;
        end else begin
            if (accept && req_write) begin
                for (int unsigned i = 0; i < NUM_CTRL; i++) begin
                    if (hit_ctrl[i]) ctrl_q[i] <= req_wdata;
                end
                if (hit_mask) mask_q <= req_wdata;
            end
            event_q       <= event_d;
            status_prev_q <= status0;
            hist_valid_q  <= 1'b1;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_error_q   <= rsp_error_d;
            wstrobe_q     <= wstrobe_d;
        end
    end

    assign ctrl_out     = ctrl_q;
    assign ctrl_wstrobe = wstrobe_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_error    = rsp_error_q;
    assign irq          = |(event_q & mask_q);

endmodule
